// File: rtl/signal_types_pkg.sv
// Shared types and constants for the DAC sample path.
//   dac_sample_t   : packed BRAM word {dac_ch0, dac_ch1}, 14-bit offset binary each
//   loader_state_t : fill-stage state machine encoding (IDLE, LOAD, DONE)
//   DAC_W / DAC_SMAX / DAC_SMIN : DAC word width and signed clamp limits
package signal_types_pkg;

    localparam int DAC_W    = 14;
    localparam int DAC_SMAX = 8191;
    localparam int DAC_SMIN = -8192;

    typedef struct packed {
        logic [DAC_W-1:0] dac_ch0;
        logic [DAC_W-1:0] dac_ch1;
    } dac_sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/dac_sample_conv.sv
// Single-channel sample conversion: clamps a signed 16-bit value to the
// 14-bit DAC range and re-encodes it as offset binary.
// Ports:
//   x   in  16      signed two's complement sample
//   y   out DAC_W   offset-binary DAC code
//   sat out 1       value was clamped
module dac_sample_conv
    import signal_types_pkg::*;
(
    input  logic [15:0]      x,
    output logic [DAC_W-1:0] y,
    output logic             sat
);

    localparam logic signed [15:0] HI = 16'(DAC_SMAX);
    localparam logic signed [15:0] LO = 16'(DAC_SMIN);

    logic signed [15:0] xs;
    logic [DAC_W-1:0]   clamped;

    always_comb begin
        xs      = $signed(x);
        sat     = 1'b0;
        clamped = x[DAC_W-1:0];
        if (xs > HI) begin
            clamped = HI[DAC_W-1:0];
            sat     = 1'b1;
        end else if (xs < LO) begin
            clamped = LO[DAC_W-1:0];
            sat     = 1'b1;
        end
        // Flipping the sign bit maps two's complement onto offset binary.
        y = {~clamped[DAC_W-1], clamped[DAC_W-2:0]};
    end

endmodule

// File: rtl/dac_mem_loader.sv
// Fill stage for the dual-channel DAC sample BRAM (port A writer).
// Accepts signed sample pairs over valid/ready, saturates and converts them
// to offset binary, and writes them to consecutive addresses from 0 for a
// programmed length. Reports busy/done/saturation/count back to the CSRs.
// Optional build macro: DAC_LOAD_CKSUM_EN enables the running checksum on
// cksum_o; when undefined cksum_o is tied to 0.
// Ports:
//   clk, rst                   clock, async active-high reset
//   load_start_i/abort_i       one-cycle control pulses
//   load_len_i                 samples to load, sampled on start
//   s_valid_i/s_ready_o        input handshake, s_ch0_i/s_ch1_i signed data
//   mem_we_o/addr_o/data_o     BRAM port A write, one cycle after transfer
//   busy_o/done_o/sat_o        status (done and sat sticky)
//   count_o                    samples accepted in current load
//   cksum_o                    running checksum of written words
module dac_mem_loader
    import signal_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start_i,
    input  logic                  load_abort_i,
    input  logic [ADDR_WIDTH-1:0] load_len_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [15:0]           s_ch0_i,
    input  logic [15:0]           s_ch1_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output dac_sample_t           mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sat_o,
    output logic [ADDR_WIDTH-1:0] count_o,
    output logic [15:0]           cksum_o
);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] len_q;
    dac_sample_t           conv_pair;
    logic                  sat_ch0;
    logic                  sat_ch1;
    logic                  xfer;
    logic                  start_ok;

    dac_sample_conv u_conv_ch0 (
        .x   (s_ch0_i),
        .y   (conv_pair.dac_ch0),
        .sat (sat_ch0)
    );

    dac_sample_conv u_conv_ch1 (
        .x   (s_ch1_i),
        .y   (conv_pair.dac_ch1),
        .sat (sat_ch1)
    );

    always_comb begin
        xfer     = s_valid_i && s_ready_o;
        // Abort beats start; start is ignored mid-load and for zero length.
        start_ok = load_start_i && !load_abort_i && (state != LOAD) &&
                   (load_len_i != '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (load_abort_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_next = LOAD;
                LOAD:    if (xfer && (count_o == len_q - ADDR_WIDTH'(1))) state_next = DONE;
                DONE:    if (start_ok) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        s_ready_o = (state == LOAD);
        busy_o    = (state == LOAD);
        done_o    = (state == DONE);
    end

    // Write port and load bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            count_o    <= '0;
            sat_o      <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            mem_we_o <= xfer;
            if (start_ok) begin
                len_q   <= load_len_i;
                count_o <= '0;
                sat_o   <= 1'b0;
            end else if (xfer) begin
                mem_addr_o <= count_o;
                mem_data_o <= conv_pair;
                count_o    <= count_o + ADDR_WIDTH'(1);
                sat_o      <= sat_o | sat_ch0 | sat_ch1;
            end
        end
    end

`ifdef DAC_LOAD_CKSUM_EN
    logic [15:0] cksum_q;

    // Accumulates from the registered write word, so each write shows up
    // one cycle after its mem_we_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum_q <= '0;
        end else if (start_ok) begin
            cksum_q <= '0;
        end else if (mem_we_o) begin
            cksum_q <= cksum_q + {2'b00, mem_data_o.dac_ch0} + {2'b00, mem_data_o.dac_ch1};
        end
    end

    assign cksum_o = cksum_q;
`else
    assign cksum_o = '0;
`endif

endmodule

// File: doc/dac_mem_loader.md
Name: dac_mem_loader

Overview:
- Upstream fill stage for the dual-channel DAC sample BRAM. It writes through port A; the playback controller reads through port B.
- Accepts signed 16-bit sample pairs from the CSR/CPU stream over a valid/ready handshake.
- Saturates each channel to 14 bits and converts it to offset binary.
- Writes samples to consecutive BRAM addresses starting at 0, for a programmed length, and reports completion and status back to the CSR block.

Parameters:
- ADDR_WIDTH, 11, BRAM address width; maximum load length is 2^ADDR_WIDTH-1 samples.

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  asynchronous active-high reset
- load_start_i  in  1  one-cycle pulse that starts a load
- load_abort_i  in  1  one-cycle pulse that aborts the load and returns to IDLE
- load_len_i  in  ADDR_WIDTH  number of samples to load; sampled on load_start_i
- s_valid_i  in  1  input sample pair valid
- s_ready_o  out  1  loader can accept a sample pair
- s_ch0_i  in  16  channel 0 sample, signed two's complement
- s_ch1_i  in  16  channel 1 sample, signed two's complement
- mem_we_o  out  1  BRAM port A write enable
- mem_addr_o  out  ADDR_WIDTH  BRAM port A write address
- mem_data_o  out  dac_sample_t  packed write data {dac_ch0, dac_ch1}, 14 bits each, offset binary
- busy_o  out  1  high while in LOAD; the top level ANDs the inverse into the playback enables
- done_o  out  1  sticky; high in DONE
- sat_o  out  1  sticky; at least one channel value was clamped during the current load
- count_o  out  ADDR_WIDTH  number of samples accepted in the current load
- cksum_o  out  16  running checksum (optional feature)

Behaviour:
- Reset values:
  - State IDLE.
  - s_ready_o, mem_we_o, busy_o, done_o and sat_o all 0.
  - mem_addr_o, mem_data_o, count_o and cksum_o all 0.
- State machine has three states: IDLE, LOAD, DONE.
- IDLE:
  - s_ready_o=0.
  - load_start_i with load_len_i>0: latch len, clear count_o, sat_o and cksum_o, go to LOAD.
  - load_start_i with load_len_i==0: ignored; stay in IDLE.
- LOAD:
  - s_ready_o=1 and busy_o=1.
  - Handshake: a transfer occurs when s_valid_i && s_ready_o.
  - Each transfer registers mem_we_o=1, mem_addr_o=count_o, mem_data_o=converted pair on the following cycle (1-cycle latency), then increments count_o.
  - mem_we_o is 0 on cycles without a transfer; mem_addr_o and mem_data_o hold their values.
  - The transfer where count_o==len-1 moves to DONE.
  - s_ready_o falls in the same cycle the state register updates, so no extra sample is accepted.
- DONE:
  - s_ready_o=0, busy_o=0, done_o=1.
  - count_o holds at len.
  - load_start_i begins a new load exactly as from IDLE, clearing done_o.
- Abort and start precedence:
  - load_abort_i in any state: go to IDLE, clear done_o, drop s_ready_o next cycle.
  - A write registered in the abort cycle still completes.
  - count_o and sat_o hold their values for debug.
  - Abort and start in the same cycle: abort wins.
  - load_start_i during LOAD is ignored.
- Conversion, per channel (combinational, ahead of the write register):
  - Clamp x to the range [-8192, 8191].
  - Output = clamped[13:0] with bit 13 inverted (offset binary).
  - sat_o sets when either channel is clamped.
- Reset mid-load: everything returns to reset values immediately. BRAM contents are undefined; playback must not be enabled before a completed load.

Optional Feature:
- Macro DAC_LOAD_CKSUM_EN.
- Defined: on each write, cksum_o = cksum_o + {2'b0,dac_ch0} + {2'b0,dac_ch1}, modulo 2^16.
  - Cleared on load start.
  - Reflects every write registered to date, including the final write, one cycle after that write's mem_we_o.
- Not defined: cksum_o is tied to 0 and no adder is synthesized.

Decomposition:
- signal_types_pkg:
  - Existing dac_sample_t (dac_ch0, dac_ch1, 14 bits each).
  - New loader_state_t enum (IDLE, LOAD, DONE).
  - Constants DAC_W=14 and DAC_SMAX=8191, DAC_SMIN=-8192.
- One sub-module, dac_sample_conv: saturation and offset-binary conversion, 16-bit signed in, 14-bit out plus a sat flag. It is instantiated once per channel.

Test Plan:
1. Conversion:
   - Stimulus: len=4; pairs (0,100), (32767,-32768), (8191,-8192), (-1,1); s_valid held high.
   - Writes expected:
     - addr0 = {2000h, 2064h}
     - addr1 = {3FFFh, 0000h}
     - addr2 = {3FFFh, 0000h}
     - addr3 = {1FFFh, 2001h}
   - Status expected: sat_o=1; done_o=1 after the 4th transfer; count_o=4.
2. Backpressure and gaps:
   - Stimulus: len=3; s_valid toggles 1,0,1,0,1.
   - Expected: exactly 3 writes to addresses 0,1,2; s_ready_o=0 the cycle after the 3rd transfer; no 4th write even though s_valid stays high.
3. Start with zero length and start while loading:
   - Start with len=0: remains IDLE, s_ready_o=0.
   - Start pulse during LOAD with len=5: ignored; the load completes with count_o=5.
4. Abort:
   - Stimulus: len=8; abort after 3 transfers.
   - Expected: IDLE; done_o=0; count_o=3; no further writes.
   - Abort and start in the same cycle: ends in IDLE.
5. Async reset mid-LOAD:
   - Expected: all outputs 0 within the reset assertion, independent of clk.
   - A new load afterwards starts at addr 0.
6. DAC_LOAD_CKSUM_EN:
   - Stimulus: pairs (0,0), (100,-1).
   - Expected: cksum = 2000h+2000h+2064h+1FFFh = 8063h.
   - Without the macro: cksum_o=0.
